// File: rtl/onewire_temp_sequencer.sv
// DS18B20-style temperature read sequencer driving a byte-level 1-Wire master.
// Issues convert, waits, reads the scratchpad and checks its CRC-8.
module onewire_temp_sequencer #(
  parameter int CONV_TICKS = 75,
  parameter int TMO_TICKS  = 10
) (
  input  logic        clk_10,
  input  logic        arst_n,
  input  logic        tick_10ms,
  input  logic        start,
  output logic        ow_vld,
  output logic [1:0]  ow_op,
  output logic [7:0]  ow_wdat,
  input  logic        ow_rdy,
  input  logic        ow_done,
  input  logic [7:0]  ow_rdat,
  input  logic        ow_presence,
  output logic        busy,
  output logic        done,
  output logic [15:0] temp,
  output logic [1:0]  err
);

  typedef enum logic [3:0] {
    IDLE, RST1, SKIP1, CONVT, WAIT, RST2,
    SKIP2, RDSP, RDBYTE, CHECK, FIN
  } state_t;

  localparam logic [1:0] OP_RST = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_RD  = 2'd2;

  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  sp_q [9];
  logic [7:0]  sp_d [9];
  logic [7:0]  crc_q, crc_d;
  logic [1:0]  res_q, res_d;
  logic [1:0]  err_q, err_d;
  logic [15:0] temp_q, temp_d;
  logic        op_st;
  logic        cmpl;

  function automatic logic [7:0] crc8(
    input logic [7:0] c,
    input logic [7:0] d
  );
    logic [7:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 8'h8C;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign temp = temp_q;
  assign err  = err_q;

  always_ff @(posedge clk_10 or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      tmo_q   <= '0;
      wcnt_q  <= '0;
      idx_q   <= '0;
      crc_q   <= '0;
      res_q   <= '0;
      err_q   <= '0;
      temp_q  <= '0;
      for (int i = 0; i < 9; i++) sp_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      tmo_q   <= tmo_d;
      wcnt_q  <= wcnt_d;
      idx_q   <= idx_d;
      crc_q   <= crc_d;
      res_q   <= res_d;
      err_q   <= err_d;
      temp_q  <= temp_d;
      for (int i = 0; i < 9; i++) sp_q[i] <= sp_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    tmo_d   = tmo_q;
    wcnt_d  = wcnt_q;
    idx_d   = idx_q;
    crc_d   = crc_q;
    res_d   = res_q;
    err_d   = err_q;
    temp_d  = temp_q;
    sp_d    = sp_q;
    ow_vld  = 1'b0;
    ow_op   = OP_RST;
    ow_wdat = 8'h00;
    op_st   = 1'b0;
    cmpl    = 1'b0;
    busy    = (state_q != IDLE);
    done    = (state_q == FIN);

    unique case (state_q)
      RST1, RST2:   op_st = 1'b1;
      SKIP1, SKIP2: begin
        op_st   = 1'b1;
        ow_op   = OP_WR;
        ow_wdat = 8'hCC;
      end
      CONVT: begin
        op_st   = 1'b1;
        ow_op   = OP_WR;
        ow_wdat = 8'h44;
      end
      RDSP: begin
        op_st   = 1'b1;
        ow_op   = OP_WR;
        ow_wdat = 8'hBE;
      end
      RDBYTE: begin
        op_st = 1'b1;
        ow_op = OP_RD;
      end
      default: ;
    endcase

    // One request per op; completion beats a same-cycle timeout
    if (op_st) begin
      if (!pend_q) begin
        ow_vld = ow_rdy;
        if (ow_rdy) begin
          pend_d = 1'b1;
          tmo_d  = '0;
        end
      end else if (ow_done) begin
        pend_d = 1'b0;
        cmpl   = 1'b1;
      end else if (tick_10ms) begin
        if (tmo_q == 16'(TMO_TICKS - 1)) begin
          pend_d  = 1'b0;
          res_d   = 2'd3;
          state_d = FIN;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RST1;
          pend_d  = 1'b0;
          idx_d   = '0;
          crc_d   = '0;
          wcnt_d  = '0;
        end
      end
      RST1: begin
        if (cmpl) begin
          if (ow_presence) state_d = SKIP1;
          else begin
            res_d   = 2'd1;
            state_d = FIN;
          end
        end
      end
      SKIP1: if (cmpl) state_d = CONVT;
      CONVT: begin
        if (cmpl) begin
          state_d = WAIT;
          wcnt_d  = '0;
        end
      end
      WAIT: begin
        if (tick_10ms) begin
          if (wcnt_q == 16'(CONV_TICKS - 1)) begin
            state_d = RST2;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + 16'd1;
          end
        end
      end
      RST2: begin
        if (cmpl) begin
          if (ow_presence) state_d = SKIP2;
          else begin
            res_d   = 2'd1;
            state_d = FIN;
          end
        end
      end
      SKIP2: if (cmpl) state_d = RDSP;
      RDSP: begin
        if (cmpl) begin
          state_d = RDBYTE;
          idx_d   = '0;
          crc_d   = '0;
        end
      end
      RDBYTE: begin
        if (cmpl) begin
          for (int i = 0; i < 9; i++)
            if (idx_q == 4'(i)) sp_d[i] = ow_rdat;
          if (idx_q < 4'd8) crc_d = crc8(crc_q, ow_rdat);
          if (idx_q == 4'd8) state_d = CHECK;
          else               idx_d   = idx_q + 4'd1;
        end
      end
      CHECK: begin
        if (crc_q == sp_q[8]) begin
          temp_d = {sp_q[1], sp_q[0]};
          res_d  = 2'd0;
        end else begin
          res_d = 2'd2;
        end
        state_d = FIN;
      end
      FIN: begin
        err_d   = res_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/onewire_temp_sequencer.md
ONEWIRE_TEMP_SEQUENCER -- requirements
Module: onewire_temp_sequencer

Interface
REQ-001 SHALL have parameter CONV_TICKS, default 75, conversion wait in tick_10ms periods (750 ms).
REQ-002 SHALL have parameter TMO_TICKS, default 10, per-operation timeout in tick_10ms periods.
REQ-003 SHALL have port clk_10  input  1  system clock, 10 MHz.
REQ-004 SHALL have port arst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tick_10ms  input  1  one-cycle strobe every 10 ms.
REQ-006 SHALL have port start  input  1  one-cycle request to run one temperature read.
REQ-007 SHALL have port ow_vld  output  1  one-cycle op request to the 1-Wire master.
REQ-008 SHALL have port ow_op  output  2  op code: 0 = reset/presence, 1 = write byte, 2 = read byte.
REQ-009 SHALL have port ow_wdat  output  8  write byte; valid with ow_vld when ow_op = 1.
REQ-010 SHALL have port ow_rdy  input  1  master idle and able to accept ow_vld.
REQ-011 SHALL have port ow_done  input  1  one-cycle op-complete strobe from master.
REQ-012 SHALL have port ow_rdat  input  8  read byte; valid with ow_done for op 2.
REQ-013 SHALL have port ow_presence  input  1  presence detected; valid with ow_done for op 0.
REQ-014 SHALL have port busy  output  1  sequence in progress.
REQ-015 SHALL have port done  output  1  one-cycle strobe at end of every sequence, success or failure.
REQ-016 SHALL have port temp  output  16  last good raw temperature (scratchpad byte1:byte0).
REQ-017 SHALL have port err  output  2  status of last sequence: 0 ok, 1 no presence, 2 CRC fail, 3 timeout.

Function
REQ-018 SHALL implement states IDLE, RST1, SKIP1, CONVT, WAIT, RST2, SKIP2, RDSP, RDBYTE, CHECK, FIN.
REQ-019 SHALL leave IDLE only on start = 1; start in any other state is ignored.
REQ-020 SHALL issue ops in order: reset, write 0xCC, write 0x44, wait, reset, write 0xCC, write 0xBE, 9 x read.
REQ-021 SHALL assert ow_vld for exactly one cycle per op, only in a cycle with ow_rdy = 1, holding ow_op/ow_wdat stable that cycle.
REQ-022 SHALL issue no further ow_vld until ow_done for the outstanding op is received.
REQ-023 SHALL advance to the next state in the cycle after ow_done.
REQ-024 SHALL, on ow_done for a reset op with ow_presence = 0, go to FIN with err = 1.
REQ-025 SHALL in WAIT count tick_10ms strobes and leave WAIT on the CONV_TICKS-th strobe; no 1-Wire traffic during WAIT.
REQ-026 SHALL store read bytes 0..8 in order into a 9-byte buffer, byte index counter 0..8, no wrap.
REQ-027 SHALL compute Dallas CRC-8 (poly x^8+x^5+x^4+1, init 0x00, LSB-first) over bytes 0..7 and in CHECK compare with byte 8.
REQ-028 SHALL on CRC match load temp = {byte1, byte0} and set err = 0; on mismatch keep temp and set err = 2.
REQ-029 SHALL count tick_10ms strobes while an op is outstanding; at TMO_TICKS strobes go to FIN with err = 3.
REQ-030 SHALL, in FIN, pulse done for one cycle and return to IDLE the next cycle.
REQ-031 SHALL drive busy = 1 in every state except IDLE.
REQ-032 SHALL ignore ow_done arriving when no op is outstanding.
REQ-033 SHALL treat simultaneous ow_done and timeout expiry as ow_done (completion wins).
REQ-034 SHALL latch err only in FIN; err holds between sequences.

Reset
REQ-035 SHALL, on arst_n = 0, asynchronously force state IDLE, ow_vld = 0, ow_op = 0, ow_wdat = 0x00, busy = 0, done = 0, temp = 0x0000, err = 0, all counters and buffer to 0.
REQ-036 SHALL, on reset mid-sequence, abandon the sequence without a done pulse; first op after reset release needs a new start.

Verification
REQ-037 Happy path: start, presence = 1, scratchpad 50 05 4B 46 7F FF 0C 10 1C -> ops in REQ-020 order, temp = 0x0550, err = 0, one done pulse.
REQ-038 No device: start, ow_presence = 0 on first reset -> no write issued, err = 1, done after RST1, temp unchanged.
REQ-039 Bad CRC: as REQ-037 but byte 8 = 0x1D -> err = 2, temp keeps previous 0x0550.
REQ-040 Timeout: withhold ow_done after write 0x44 -> done after 10 tick_10ms strobes, err = 3, busy = 0.
REQ-041 Flow control: hold ow_rdy = 0 for 50 cycles at each op -> ow_vld only when ow_rdy = 1, exactly one per op, 0 then 1 on next start.
REQ-042 Reset mid-WAIT: arst_n low at WAIT tick 30 -> all outputs at reset values, no done, new start runs full sequence.
